// File: rtl/learn_sequencer_pkg.sv
// learn_pkg: shared constants, FSM state encoding and arithmetic helpers
// for the bit-prediction learning sequencer.
//   N_W_DEF      number of weights / history depth
//   W_BITS_DEF   signed weight width (FRAC fractional bits)
//   ETA_DEF      update step in weight LSBs
//   GAMMA_SQ_DEF norm-squared threshold, 2*FRAC fractional bits
package learn_pkg;

    localparam int N_W_DEF      = 20;
    localparam int W_BITS_DEF   = 10;
    localparam int FRAC         = 5;
    localparam int ETA_DEF      = 2;
    localparam int GAMMA_SQ_DEF = 2025;

    typedef enum logic [2:0] {
        IDLE,
        UPD,
        SHF,
        NRM,
        CHK,
        SCL,
        PRD,
        FIN
    } state_t;

    // Bit-to-sign map: 0 -> +1, 1 -> -1.
    function automatic int s_of(input logic b);
        return b ? -1 : 1;
    endfunction

    // a + b clamped to the two's complement range of a w_bits-wide word.
    function automatic int sat_add(input int a, input int b, input int w_bits);
        int sum;
        int hi;
        int lo;
        int res;
        sum = a + b;
        hi  = (1 << (w_bits - 1)) - 1;
        lo  = -(1 << (w_bits - 1));
        if (sum > hi)
            res = hi;
        else if (sum < lo)
            res = lo;
        else
            res = sum;
        return res;
    endfunction

endpackage

// File: rtl/learn_sequencer_if.sv
// learn_sequencer_if: event input and prediction output bundle.
//   bit_valid/bit_in   new debounced input bit (master -> slave)
//   busy               sequencer is mid-pass
//   pred/pred_valid    predicted next bit and its one-cycle update strobe
//   led                saturating hit count
//   ovf                sticky dropped-event flag
interface learn_sequencer_if;
    import learn_pkg::*;

    logic       bit_valid;
    logic       bit_in;
    logic       busy;
    logic       pred;
    logic       pred_valid;
    logic [7:0] led;
    logic       ovf;

    modport master (
        output bit_valid, bit_in,
        input  busy, pred, pred_valid, led, ovf
    );

    modport slave (
        input  bit_valid, bit_in,
        output busy, pred, pred_valid, led, ovf
    );

endinterface

// File: rtl/learn_sequencer_weight_bank.sv
// weight_bank: N_W x W_BITS signed register file, reset to zero.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_idx         shared read/write address
//   i_we, i_wdata synchronous write port
//   o_rdata       combinational read port
module weight_bank
    import learn_pkg::*;
#(
    parameter int N_W      = N_W_DEF,
    parameter int W_BITS   = W_BITS_DEF,
    parameter int IDX_BITS = $clog2(N_W)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [IDX_BITS-1:0]        i_idx,
    input  logic                       i_we,
    input  logic signed [W_BITS-1:0]   i_wdata,
    output logic signed [W_BITS-1:0]   o_rdata
);

    logic signed [W_BITS-1:0] r_mem [N_W];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N_W; i++)
                r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/learn_sequencer.sv
// learn_sequencer: serial learn-and-predict engine. Each accepted bit runs
// UPD -> SHF -> NRM -> CHK -> (SCL) -> PRD -> FIN, one weight per clock.
//   CLOCK_50  system clock
//   rst       synchronous active-high reset; aborts any pass
//   bus       learn_sequencer_if slave: bit_valid/bit_in in,
//             busy/pred/pred_valid/led/ovf out
module learn_sequencer
    import learn_pkg::*;
#(
    parameter int N_W      = N_W_DEF,
    parameter int W_BITS   = W_BITS_DEF,
    parameter int ETA      = ETA_DEF,
    parameter int GAMMA_SQ = GAMMA_SQ_DEF
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    learn_sequencer_if.slave   bus
);

    localparam int IDX_BITS = $clog2(N_W);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(N_W - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_BITS-1:0]        r_idx;
    logic [N_W-1:0]             r_xh;
    logic                       r_xin;
    logic                       r_hit;
    logic                       r_pred;
    logic                       r_pred_valid;
    logic [7:0]                 r_led;
    logic                       r_ovf;
    logic [23:0]                r_acc;
    logic signed [14:0]         r_y;

    logic signed [W_BITS-1:0]   w_rd;
    logic signed [W_BITS-1:0]   w_wd;
    logic                       w_we;
    logic                       w_last;
    logic                       w_hit_now;
    logic signed [2*W_BITS-1:0] w_rd_ext;
    logic signed [2*W_BITS-1:0] w_sq;
    logic signed [14:0]         w_term;

    weight_bank #(
        .N_W      (N_W),
        .W_BITS   (W_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_bank (
        .i_clk   (CLOCK_50),
        .i_rst   (rst),
        .i_idx   (r_idx),
        .i_we    (w_we),
        .i_wdata (w_wd),
        .o_rdata (w_rd)
    );

    assign w_last    = (r_idx == IDX_LAST);
    assign w_hit_now = (bus.bit_in == r_pred);
    assign w_rd_ext  = w_rd;
    assign w_sq      = w_rd_ext * w_rd_ext;
    assign w_term    = r_xh[r_idx] ? -15'(w_rd) : 15'(w_rd);

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_wd        = w_rd;
        unique case (r_state)
            IDLE: if (bus.bit_valid) w_state_nxt = UPD;
            UPD: begin
                // History still holds the pre-shift bits here.
                w_we = !r_hit;
                w_wd = W_BITS'(sat_add(int'(w_rd),
                                       ETA * s_of(r_xin) * s_of(r_xh[r_idx]),
                                       W_BITS));
                if (w_last) w_state_nxt = SHF;
            end
            SHF: w_state_nxt = NRM;
            NRM: if (w_last) w_state_nxt = CHK;
            CHK: w_state_nxt = (r_acc > 24'(GAMMA_SQ)) ? SCL : PRD;
            SCL: begin
                w_we = 1'b1;
                w_wd = w_rd >>> 1;
                if (w_last) w_state_nxt = PRD;
            end
            PRD: if (w_last) w_state_nxt = FIN;
            FIN: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_xh         <= '0;
            r_xin        <= 1'b0;
            r_hit        <= 1'b0;
            r_pred       <= 1'b0;
            r_pred_valid <= 1'b0;
            r_led        <= '0;
            r_ovf        <= 1'b0;
            r_acc        <= '0;
            r_y          <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pred_valid <= 1'b0;

            // idx sweeps 0..N_W-1 in each serial phase and sits at 0 elsewhere,
            // so every phase starts from weight 0.
            if (r_state inside {UPD, NRM, SCL, PRD})
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            else
                r_idx <= '0;

            if (bus.bit_valid && r_state != IDLE)
                r_ovf <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (bus.bit_valid) begin
                        r_xin <= bus.bit_in;
                        r_hit <= w_hit_now;
                        if (w_hit_now && r_led != '1)
                            r_led <= r_led + 1'b1;
                    end
                end
                SHF: begin
                    r_xh  <= {r_xh[N_W-2:0], r_xin};
                    r_acc <= '0;
                end
                NRM: r_acc <= r_acc + 24'($unsigned(w_sq));
                // y is cleared here since both SCL and PRD follow CHK.
                CHK: r_y <= '0;
                PRD: r_y <= r_y + w_term;
                FIN: begin
                    r_pred       <= (r_y < 0);
                    r_pred_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.pred       = r_pred;
    assign bus.pred_valid = r_pred_valid;
    assign bus.led        = r_led;
    assign bus.ovf        = r_ovf;

endmodule
